// File: rtl/note_input_ctrl_pkg.sv
// note_input_pkg: shared definitions for the guitar-controller input block.
// Holds the Avalon register addresses, the bit positions used inside the
// STATUS/CTRL/EVENT words, the queued event record and a helper that
// formats a queued event as the EVENT register word.
package note_input_pkg;

    localparam int FRET_W = 5;

    // Word addresses on the lightweight bus
    localparam logic [1:0] ADDR_EVENT  = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_LED    = 2'd3;

    // EVENT word layout
    localparam int EV_VALID_BIT = 31;
    localparam int EV_FRETS_LSB = 24;

    // STATUS word layout
    localparam int ST_OVF_BIT   = 8;
    localparam int ST_FRETS_LSB = 16;
    localparam int ST_STRUM_BIT = 21;
    localparam int ST_KEYS_LSB  = 24;

    // CTRL word layout
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    typedef struct packed {
        logic [FRET_W-1:0] frets;
        logic [23:0]       ts;
    } note_event_t;

    // A queued event always reads back with the valid flag set
    function automatic logic [31:0] pack_event(input note_event_t ev);
        logic [31:0] word;
        word = '0;
        word[EV_VALID_BIT] = 1'b1;
        word[EV_FRETS_LSB +: FRET_W] = ev.frets;
        word[23:0] = ev.ts;
        return word;
    endfunction

endpackage

// File: rtl/note_input_ctrl_if.sv
// note_input_ctrl_if: Avalon-MM slave bus between the HPS bridge and the
// note input controller.
//   chipselect, read, write : access strobes (master -> slave)
//   address[1:0]            : word address
//   writedata[31:0]         : write data
//   readdata[31:0]          : registered read data, one cycle read latency
//   irq                     : level interrupt (slave -> master)
interface note_input_ctrl_if;

    logic        chipselect;
    logic        read;
    logic        write;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output chipselect, read, write, address, writedata,
        input  readdata, irq
    );

    modport slave (
        input  chipselect, read, write, address, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/note_input_ctrl_input_debouncer.sv
// input_debouncer: two-flop synchroniser followed by a per-bit debounce
// counter for a vector of active-low inputs.
//   clk, reset_n : clock, asynchronous active-low reset
//   raw_n        : raw active-low input pins
//   stable       : debounced level, active-high (1 = pressed)
// A bit's stable value flips only after the synchronised sample has
// differed from it for DEBOUNCE_CYCLES consecutive cycles, giving a total
// pin-to-output latency of DEBOUNCE_CYCLES+2 cycles.
module input_debouncer #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_n,
    output logic [WIDTH-1:0] stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_n;
    logic [WIDTH-1:0] sync2_n;
    logic [WIDTH-1:0] stable_n;
    logic [CNT_W-1:0] cnt [WIDTH];

    // Everything resets to the released level so no press is seen until
    // a pin has genuinely been held long enough after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_n  <= '1;
            sync2_n  <= '1;
            stable_n <= '1;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync1_n <= raw_n;
            sync2_n <= sync1_n;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_n[i] == stable_n[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable_n[i] <= sync2_n[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign stable = ~stable_n;

endmodule

// File: rtl/note_input_ctrl.sv
// note_input_ctrl: Avalon-MM slave owning the guitar-controller inputs
// (five frets, strum, four board KEYs) and the eight red LEDs. Each strum
// press, when enabled, queues {frets, ms timestamp} in an event FIFO that
// the HPS drains; irq signals pending events.
//   clk, reset_n : clock, asynchronous active-low reset
//   pins_n[5:0]  : active-low frets [4:0] green..orange, strum [5]
//   key_n[3:0]   : active-low board KEYs
//   ledr[7:0]    : LED register output, active-high
//   bus          : Avalon-MM slave (note_input_ctrl_if.slave)
// Build option: define NOTE_KEY_STRUM_EN to let a debounced KEY[0] press
// act as a strum (the two are ORed before edge detection).
module note_input_ctrl
    import note_input_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 8,
    parameter int TS_WIDTH        = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         pins_n,
    input  logic [3:0]         key_n,
    output logic [7:0]         ledr,
    note_input_ctrl_if.slave   bus
);

    localparam int PRESCALE = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    logic [5:0]          pins_q;
    logic [3:0]          keys_q;
    logic [PS_W-1:0]     presc;
    logic [TS_WIDTH-1:0] ms_cnt;
    logic                trig, trig_d, push_req;
    logic                ctrl_enable, ctrl_irq_en, overflow;
    logic [7:0]          led_q;
    logic [31:0]         readdata_q, rd_mux;
    logic                irq_q;
    note_event_t         mem [FIFO_DEPTH];
    note_event_t         new_event;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                empty, full, bus_rd, bus_wr;
    logic                pop, push_ok, drop, flush, ovf_clr;
    logic                unused_wdata;

    input_debouncer #(.WIDTH(6), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pins_db (
        .clk(clk), .reset_n(reset_n), .raw_n(pins_n), .stable(pins_q)
    );

    input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_keys_db (
        .clk(clk), .reset_n(reset_n), .raw_n(key_n), .stable(keys_q)
    );

`ifdef NOTE_KEY_STRUM_EN
    assign trig = pins_q[5] | keys_q[0];
`else
    assign trig = pins_q[5];
`endif

    // Millisecond timestamp: prescaler wraps once per ms, ms counter wraps
    // naturally at 2^TS_WIDTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (presc == PS_W'(PRESCALE - 1)) begin
            presc  <= '0;
            ms_cnt <= ms_cnt + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign bus_rd   = bus.chipselect & bus.read;
    assign bus_wr   = bus.chipselect & bus.write;
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign push_req = ctrl_enable & trig & ~trig_d;
    assign pop      = bus_rd & (bus.address == ADDR_EVENT) & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign flush    = bus_wr & (bus.address == ADDR_CTRL) & bus.writedata[CTRL_FLUSH_BIT];
    assign ovf_clr  = bus_wr & (bus.address == ADDR_STATUS) & bus.writedata[ST_OVF_BIT];
    assign new_event = '{frets: pins_q[FRET_W-1:0], ts: 24'(ms_cnt)};
    assign unused_wdata = ^{bus.writedata[31:9]};

    // Event FIFO bookkeeping; a flush overrides any push or pop this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_d   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            trig_d <= trig;
            if (drop && !flush) overflow <= 1'b1;
            else if (ovf_clr)   overflow <= 1'b0;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                if (push_ok && !pop)      count <= count + 1'b1;
                else if (!push_ok && pop) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= new_event;
    end

    // Control and LED registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_enable <= 1'b0;
            ctrl_irq_en <= 1'b0;
            led_q       <= '0;
        end else if (bus_wr) begin
            if (bus.address == ADDR_CTRL) begin
                ctrl_enable <= bus.writedata[CTRL_EN_BIT];
                ctrl_irq_en <= bus.writedata[CTRL_IRQ_EN_BIT];
            end
            if (bus.address == ADDR_LED) led_q <= bus.writedata[7:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_EVENT: if (!empty) rd_mux = pack_event(mem[rd_ptr]);
            ADDR_STATUS: begin
                rd_mux[3:0]                     = 4'(count);
                rd_mux[ST_OVF_BIT]              = overflow;
                rd_mux[ST_FRETS_LSB +: FRET_W]  = pins_q[FRET_W-1:0];
                rd_mux[ST_STRUM_BIT]            = pins_q[5];
                rd_mux[ST_KEYS_LSB +: 4]        = keys_q;
            end
            ADDR_CTRL: begin
                rd_mux[CTRL_EN_BIT]     = ctrl_enable;
                rd_mux[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
            end
            default: rd_mux[7:0] = led_q;
        endcase
    end

    // Registered read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (bus_rd) readdata_q <= rd_mux;
            irq_q <= ctrl_irq_en & ~empty;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;
    assign ledr         = led_q;

endmodule

// File: tb/tb_note_input_ctrl.sv
// tb_note_input_ctrl: scoreboard bench for note_input_ctrl with a short
// debounce (4 cycles) and a 10-cycle millisecond. Bus reads push their
// expected word into a queue; a monitor compares readdata in the read
// latency slot. Event timestamps come from an independent edge counter:
// a pin driven just after edge count e0 is accepted with ms=(e0+6)/10.
module tb_note_input_ctrl;
    import note_input_pkg::*;

    localparam int D      = 4;
    localparam int MS_CYC = 10;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  pins_n;
    logic [3:0]  key_n;
    logic [7:0]  ledr;
    logic        rd_slot;
    int          edges;
    int          total = 0;
    int          bad = 0;
    sb_item_t    sb_q[$];
    logic [28:0] model_q[$];

    note_input_ctrl_if bus();

    note_input_ctrl #(
        .CLK_HZ(MS_CYC * 1000), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(8), .TS_WIDTH(24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pins_n(pins_n), .key_n(key_n),
        .ledr(ledr), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_slot <= 1'b0;
        else          rd_slot <= bus.chipselect & bus.read;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: readdata is valid in the cycle after a read strobe
    always @(negedge clk) begin
        if (rd_slot) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_read: got 0x%08h expected no read", bus.readdata);
            end else begin
                sb_item_t it;
                it = sb_q.pop_front();
                checkOutput(it.name, bus.readdata, it.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ts_for(input int e0);
        return 24'((e0 + D + 2) / MS_CYC);
    endfunction

    task automatic applyStimulus(input logic [5:0] p, input logic [3:0] k, output int e0);
        pins_n = p;
        key_n  = k;
        e0     = edges;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, input string name, input logic [31:0] exp);
        sb_q.push_back('{name, exp});
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        tick(1);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic expectEvent(input string name);
        logic [31:0] e;
        logic [28:0] m;
        e = '0;
        if (model_q.size() > 0) begin
            m = model_q.pop_front();
            e = {1'b1, 2'b00, m};
        end
        bus_read(ADDR_EVENT, name, e);
    endtask

    task automatic strumOnce(input logic [4:0] frets_n, input bit expect_push);
        int e0;
        applyStimulus({1'b0, frets_n}, 4'hF, e0);
        if (expect_push) model_q.push_back({~frets_n, ts_for(e0)});
        tick(8);
        applyStimulus({1'b1, frets_n}, 4'hF, e0);
        tick(8);
    endtask

    initial begin
        int e0;
        pins_n = 6'h3F;
        key_n  = 4'hF;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = '0;

        // Reset state
        tick(3);
        checkOutput("reset_irq", 32'(bus.irq), 32'd0);
        checkOutput("reset_ledr", 32'(ledr), 32'd0);
        checkOutput("reset_readdata", bus.readdata, 32'd0);
        reset_n = 1'b1;
        tick(2);
        bus_read(ADDR_EVENT, "reset_event", 32'h0);
        bus_read(ADDR_STATUS, "reset_status", 32'h0);
        bus_read(ADDR_CTRL, "reset_ctrl", 32'h0);
        bus_read(ADDR_LED, "reset_led", 32'h0);

        // LED register
        bus_write(ADDR_LED, 32'h0000_01A5);
        checkOutput("ledr_write", 32'(ledr), 32'h0000_00A5);
        bus_read(ADDR_LED, "led_read", 32'h0000_00A5);

        // Bouncing strum, then a clean hold: exactly one event
        bus_write(ADDR_CTRL, 32'h1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 6'h1F : 6'h3F, 4'hF, e0);
            tick(2);
        end
        bus_read(ADDR_STATUS, "bounce_no_event", 32'h0);
        applyStimulus(6'h1F, 4'hF, e0);
        model_q.push_back({5'b0, ts_for(e0)});
        tick(8);
        bus_read(ADDR_STATUS, "bounce_one_event", 32'h0020_0001);
        applyStimulus(6'h3F, 4'hF, e0);
        tick(10);
        bus_read(ADDR_STATUS, "release_no_event", 32'h0000_0001);
        expectEvent("bounce_event");
        expectEvent("bounce_drained");

        // Chord capture with interrupts
        bus_write(ADDR_CTRL, 32'h3);
        applyStimulus(6'b111010, 4'hF, e0);
        tick(8);
        applyStimulus(6'b011010, 4'hF, e0);
        model_q.push_back({5'b00101, ts_for(e0)});
        tick(7);
        checkOutput("irq_before", 32'(bus.irq), 32'd0);
        tick(1);
        checkOutput("irq_rise", 32'(bus.irq), 32'd1);
        expectEvent("chord_event");
        expectEvent("chord_drained");
        tick(1);
        checkOutput("irq_drop", 32'(bus.irq), 32'd0);
        applyStimulus(6'h3F, 4'hF, e0);
        tick(8);

        // Overflow: nine strums into eight slots
        bus_write(ADDR_CTRL, 32'h1);
        for (int i = 0; i < 9; i++) strumOnce(5'h1F, model_q.size() < 8);
        bus_read(ADDR_STATUS, "overflow_set", 32'h0000_0108);
        bus_write(ADDR_STATUS, 32'h0000_0100);
        bus_read(ADDR_STATUS, "overflow_clear", 32'h0000_0008);

        // Push and pop in the same cycle while full
        applyStimulus(6'h1F, 4'hF, e0);
        tick(6);
        expectEvent("full_pushpop_event");
        model_q.push_back({5'b0, ts_for(e0)});
        bus_read(ADDR_STATUS, "full_pushpop_status", 32'h0020_0008);
        applyStimulus(6'h3F, 4'hF, e0);
        tick(8);
        for (int i = 0; i < 8; i++) expectEvent($sformatf("drain_%0d", i));
        expectEvent("drain_empty");

        // Flush coincident with a push
        applyStimulus(6'h1F, 4'hF, e0);
        tick(6);
        bus_write(ADDR_CTRL, 32'h5);
        bus_read(ADDR_STATUS, "flush_vs_push", 32'h0020_0000);
        bus_read(ADDR_CTRL, "flush_reads_zero", 32'h0000_0001);
        applyStimulus(6'h3F, 4'hF, e0);
        tick(8);

        // Reset pulsed mid-debounce
        applyStimulus(6'h1F, 4'hF, e0);
        tick(3);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(12);
        bus_read(ADDR_STATUS, "reset_mid_status", 32'h0020_0000);
        bus_read(ADDR_CTRL, "reset_mid_ctrl", 32'h0);
        checkOutput("reset_mid_irq", 32'(bus.irq), 32'd0);
        applyStimulus(6'h3F, 4'hF, e0);
        tick(8);

        // KEY[0] press: an event only with NOTE_KEY_STRUM_EN
        bus_write(ADDR_CTRL, 32'h1);
        applyStimulus(6'h3F, 4'hE, e0);
`ifdef NOTE_KEY_STRUM_EN
        model_q.push_back({5'b0, ts_for(e0)});
        tick(8);
        bus_read(ADDR_STATUS, "key_status", 32'h0100_0001);
`else
        tick(8);
        bus_read(ADDR_STATUS, "key_status", 32'h0100_0000);
`endif
        applyStimulus(6'h3F, 4'hF, e0);
        tick(8);
        expectEvent("key_event");
        expectEvent("key_drained");

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick(1);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
